// File: rtl/pcm_adc_rx.sv
// pcm_adc_rx: master-mode serial receiver for PCM1801-class ADCs.
// Divides scki into bck/lrck and deserialises dout into stereo pairs.
module pcm_adc_rx #(
  parameter int SAMPLE_W     = 16,
  parameter int BCK_DIV_LOG2 = 3,
  parameter int SLOT_LOG2    = 4,
  parameter int I2S_MODE     = 0
) (
  input  logic                scki,
  input  logic                reset,
  input  logic                dout,
  output logic                lrck,
  output logic                bck,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right,
  output logic                valid,
  input  logic                ready,
  output logic                overrun,
  input  logic                ovr_clr
);

  localparam int C      = BCK_DIV_LOG2 + SLOT_LOG2 + 2;
  localparam int D      = BCK_DIV_LOG2 + 1;
  localparam int KFIRST = (I2S_MODE != 0) ? 1 : 0;
  localparam int KLAST  = SAMPLE_W - 1 + KFIRST;
  localparam logic [D-1:0] PH = D'((1 << BCK_DIV_LOG2) - 1);

  logic [C-1:0]          cnt;
  logic [SLOT_LOG2-1:0]  k;
  logic                  smp;
  logic                  in_win;
  logic                  last;
  logic                  cap_l;
  logic                  cap_r;
  logic                  commit;
  logic [SAMPLE_W-1:0]   sr_l;
  logic [SAMPLE_W-1:0]   sr_r;
  logic [SAMPLE_W-1:0]   hold;
  logic [SAMPLE_W-1:0]   nxt_l;
  logic [SAMPLE_W-1:0]   nxt_r;

  assign bck    = cnt[BCK_DIV_LOG2];
  assign lrck   = cnt[C-1];
  assign k      = cnt[C-2:D];

  // sample on the scki edge where bck rises
  assign smp    = (cnt[D-1:0] == PH);
  assign in_win = (int'(k) >= KFIRST) && (int'(k) <= KLAST);
  assign last   = (int'(k) == KLAST);
  assign cap_l  = smp && in_win && !lrck;
  assign cap_r  = smp && in_win && lrck;
  assign commit = cap_r && last;

  assign nxt_l  = {sr_l[SAMPLE_W-2:0], dout};
  assign nxt_r  = {sr_r[SAMPLE_W-2:0], dout};

  always_ff @(posedge scki or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      sr_l    <= '0;
      sr_r    <= '0;
      hold    <= '0;
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= cnt + C'(1);
      if (cap_l) begin
        sr_l <= nxt_l;
        if (last)
          hold <= nxt_l;
      end
      if (cap_r)
        sr_r <= nxt_r;
      if (commit) begin
        left  <= hold;
        right <= nxt_r;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // a fresh overrun beats a simultaneous clear
      if (commit && valid && !ready)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_adc_rx.sv
// tb_pcm_adc_rx: randomized bench for pcm_adc_rx in left-justified
// 16-bit and I2S 24-bit/32-slot configurations.
module tb_pcm_adc_rx;

  logic        scki = 1'b0;
  logic        reset = 1'b1;
  logic        dout_a = 1'b0;
  logic        dout_b = 1'b0;
  logic        ready_a = 1'b0;
  logic        ready_b = 1'b1;
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;
  logic        lrck_a, bck_a, valid_a, overrun_a;
  logic        lrck_b, bck_b, valid_b, overrun_b;
  logic [15:0] left_a, right_a;
  logic [23:0] left_b, right_b;

  int vectors = 0;
  int miscompares = 0;
  int tc;

  logic [15:0] la [8];
  logic [15:0] ra [8];
  logic [23:0] lb [8];
  logic [23:0] rb [8];

  pcm_adc_rx u_a (
    .scki(scki), .reset(reset), .dout(dout_a),
    .lrck(lrck_a), .bck(bck_a),
    .left(left_a), .right(right_a),
    .valid(valid_a), .ready(ready_a),
    .overrun(overrun_a), .ovr_clr(clr_a)
  );

  pcm_adc_rx #(
    .SAMPLE_W(24), .BCK_DIV_LOG2(3),
    .SLOT_LOG2(5), .I2S_MODE(1)
  ) u_b (
    .scki(scki), .reset(reset), .dout(dout_b),
    .lrck(lrck_b), .bck(bck_b),
    .left(left_b), .right(right_b),
    .valid(valid_b), .ready(ready_b),
    .overrun(overrun_b), .ovr_clr(clr_b)
  );

  always #5 scki = ~scki;

  // scki cycles since reset release: the expected frame position
  always @(posedge scki or posedge reset)
    if (reset) tc <= 0;
    else tc <= tc + 1;

  // LJ 16-bit in a 16-bit slot: 256 scki per slot, 16 per bit
  function automatic logic bit_a(int t);
    int f, pos, k;
    f = (t / 512) % 8;
    pos = t % 512;
    k = (pos % 256) / 16;
    return (pos < 256) ? la[f][15-k] : ra[f][15-k];
  endfunction

  // I2S 24-bit in a 32-bit slot: bit 0 is a decoy, bits 25..31 junk
  function automatic logic bit_b(int t);
    int f, pos, k;
    f = (t / 1024) % 8;
    pos = t % 1024;
    k = (pos % 512) / 16;
    if (k == 0) return 1'b1;
    if (k > 24) return 1'($urandom);
    return (pos < 512) ? lb[f][24-k] : rb[f][24-k];
  endfunction

  always @(negedge scki) begin
    dout_a = bit_a(tc);
    dout_b = bit_b(tc);
  end

  task automatic randomize_data();
    for (int i = 0; i < 8; i++) begin
      la[i] = 16'($urandom) | 16'h0001;
      ra[i] = 16'($urandom) | 16'h0001;
      lb[i] = 24'($urandom) | 24'h000001;
      rb[i] = 24'($urandom) | 24'h000001;
    end
  endtask

  task automatic do_reset();
    @(negedge scki);
    reset = 1'b1;
    repeat (3) @(negedge scki);
    reset = 1'b0;
  endtask

  task automatic wait_post(int target);
    int n;
    n = 0;
    do begin
      @(posedge scki);
      #1;
      n++;
    end while (tc != target && n < 5000);
    if (tc != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_post timeout got tc=%0d need %0d", tc, target);
    end
  endtask

  task automatic wait_neg(int target);
    int n;
    n = 0;
    do begin
      @(negedge scki);
      n++;
    end while (tc != target && n < 5000);
    if (tc != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_neg timeout got tc=%0d need %0d", tc, target);
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp3;
    randomize_data();
    ready_a = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge scki);
    vectors++;
    if ({lrck_a, bck_a, valid_a, overrun_a, left_a, right_a} !== '0) begin
      miscompares++;
      $display("FAIL reset_a got %b%b%b%b %h %h need all 0",
               lrck_a, bck_a, valid_a, overrun_a, left_a, right_a);
    end
    vectors++;
    if ({lrck_b, bck_b, valid_b, overrun_b, left_b, right_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_b got %b%b%b%b %h %h need all 0",
               lrck_b, bck_b, valid_b, overrun_b, left_b, right_b);
    end
    reset = 1'b0;
    repeat (1100) begin
      @(posedge scki);
      #1;
      exp3 = {1'((tc / 8) % 2), 1'((tc / 256) % 2),
              1'(tc % 512 == 504)};
      vectors++;
      if ({bck_a, lrck_a, valid_a} !== exp3) begin
        miscompares++;
        $display("FAIL clocks_a t=%0d got bck/lrck/valid=%b need %b",
                 tc, {bck_a, lrck_a, valid_a}, exp3);
      end
      vectors++;
      if (lrck_b !== 1'((tc / 512) % 2)) begin
        miscompares++;
        $display("FAIL lrck_b t=%0d got %b need %b",
                 tc, lrck_b, 1'((tc / 512) % 2));
      end
    end
  endtask

  task automatic test_lj();
    int f, p;
    randomize_data();
    la[0] = 16'h8001;
    ra[0] = 16'h7FFE;
    ready_a = 1'b1;
    do_reset();
    repeat (4 * 512) begin
      @(posedge scki);
      #1;
      p = tc % 512;
      f = (tc / 512) % 8;
      vectors++;
      if (p == 504) begin
        if ({valid_a, overrun_a, left_a, right_a} !==
            {2'b10, la[f], ra[f]}) begin
          miscompares++;
          $display("FAIL lj_commit t=%0d got v=%b o=%b l=%h r=%h need v=1 o=0 l=%h r=%h",
                   tc, valid_a, overrun_a, left_a, right_a, la[f], ra[f]);
        end
      end else if (valid_a !== 1'b0) begin
        miscompares++;
        $display("FAIL lj_valid_pulse t=%0d got %b need 0", tc, valid_a);
      end
    end
  endtask

  task automatic test_i2s();
    int f, p;
    randomize_data();
    lb[0] = 24'h123456;
    rb[0] = 24'hABCDEF;
    ready_b = 1'b1;
    do_reset();
    repeat (3 * 1024) begin
      @(posedge scki);
      #1;
      p = tc % 1024;
      f = (tc / 1024) % 8;
      vectors++;
      if (p == 904) begin
        if ({valid_b, overrun_b, left_b, right_b} !==
            {2'b10, lb[f], rb[f]}) begin
          miscompares++;
          $display("FAIL i2s_commit t=%0d got v=%b o=%b l=%h r=%h need v=1 o=0 l=%h r=%h",
                   tc, valid_b, overrun_b, left_b, right_b, lb[f], rb[f]);
        end
      end else if (valid_b !== 1'b0) begin
        miscompares++;
        $display("FAIL i2s_valid_pulse t=%0d got %b need 0", tc, valid_b);
      end
    end
  endtask

  task automatic test_overrun();
    randomize_data();
    la[0] = 16'hAAAA;
    ra[0] = 16'h5555;
    la[1] = 16'h1234;
    ra[1] = 16'h4321;
    ready_a = 1'b0;
    clr_a = 1'b0;
    do_reset();
    wait_post(504);
    vectors++;
    if ({valid_a, overrun_a, left_a, right_a} !== {2'b10, 16'hAAAA, 16'h5555}) begin
      miscompares++;
      $display("FAIL ovr_first got v=%b o=%b l=%h r=%h need v=1 o=0 l=aaaa r=5555",
               valid_a, overrun_a, left_a, right_a);
    end
    wait_post(1016);
    vectors++;
    if ({valid_a, overrun_a, left_a, right_a} !== {2'b11, 16'h1234, 16'h4321}) begin
      miscompares++;
      $display("FAIL ovr_second got v=%b o=%b l=%h r=%h need v=1 o=1 l=1234 r=4321",
               valid_a, overrun_a, left_a, right_a);
    end
    @(negedge scki);
    clr_a = 1'b1;
    @(negedge scki);
    clr_a = 1'b0;
    vectors++;
    if ({valid_a, overrun_a} !== 2'b10) begin
      miscompares++;
      $display("FAIL ovr_clear got v=%b o=%b need v=1 o=0", valid_a, overrun_a);
    end
    @(negedge scki);
    clr_a = 1'b1;
    wait_post(1528);
    vectors++;
    if ({valid_a, overrun_a, left_a} !== {2'b11, la[2]}) begin
      miscompares++;
      $display("FAIL ovr_set_wins got v=%b o=%b l=%h need v=1 o=1 l=%h",
               valid_a, overrun_a, left_a, la[2]);
    end
    @(negedge scki);
    clr_a = 1'b0;
    ready_a = 1'b1;
    @(negedge scki);
    ready_a = 1'b0;
    vectors++;
    if ({valid_a, overrun_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL ovr_consume got v=%b o=%b need v=0 o=1", valid_a, overrun_a);
    end
  endtask

  task automatic test_back_to_back();
    randomize_data();
    ready_a = 1'b0;
    clr_a = 1'b0;
    do_reset();
    wait_post(504);
    vectors++;
    if (valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got v=%b need 1", valid_a);
    end
    wait_neg(1015);
    ready_a = 1'b1;
    @(posedge scki);
    #1;
    vectors++;
    if ({valid_a, overrun_a, left_a, right_a} !== {2'b10, la[1], ra[1]}) begin
      miscompares++;
      $display("FAIL b2b_commit got v=%b o=%b l=%h r=%h need v=1 o=0 l=%h r=%h",
               valid_a, overrun_a, left_a, right_a, la[1], ra[1]);
    end
    @(posedge scki);
    #1;
    ready_a = 1'b0;
    vectors++;
    if (valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drop got v=%b need 0", valid_a);
    end
  endtask

  task automatic test_midreset();
    int p;
    randomize_data();
    ready_a = 1'b0;
    clr_a = 1'b0;
    do_reset();
    wait_post(1016);
    wait_neg(1124);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({lrck_a, bck_a, valid_a, overrun_a, left_a, right_a} !== '0) begin
      miscompares++;
      $display("FAIL midreset_async got %b%b%b%b %h %h need all 0",
               lrck_a, bck_a, valid_a, overrun_a, left_a, right_a);
    end
    randomize_data();
    repeat (2) @(negedge scki);
    reset = 1'b0;
    ready_a = 1'b1;
    do begin
      @(posedge scki);
      #1;
      p = tc;
      vectors++;
      if (p < 504 && valid_a !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_early t=%0d got v=%b need 0", tc, valid_a);
      end else if (p == 504 &&
          {valid_a, overrun_a, left_a, right_a} !== {2'b10, la[0], ra[0]}) begin
        miscompares++;
        $display("FAIL midreset_frame got v=%b o=%b l=%h r=%h need v=1 o=0 l=%h r=%h",
                 valid_a, overrun_a, left_a, right_a, la[0], ra[0]);
      end
    end while (p < 504);
    ready_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lj();
    test_i2s();
    test_overrun();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
